// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and defaults for the LED step counter controller.
//   state_t    : controller FSM states (IDLE, PRESS, REPEAT)
//   cmd_t      : arbitrated button command (NONE, UP, DN)
//   DEF_*      : default parameter values used by counter_step_ctrl and
//                counter_tick_gen
//   cnt_w()    : safe counter width for a modulus (never below 1 bit)
//   decode_cmd : button pair -> command, both pressed counts as no command
//   step_pulse : direction + permission -> {step_dn, step_up} pulse pair
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRESS  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_UP   = 2'd1,
      CMD_DN   = 2'd2
   } cmd_t;

   localparam int DEF_WIDTH        = 4;
   localparam int DEF_TICK_DIV     = 1250000;  // 10 ms at 125 MHz
   localparam int DEF_HOLD_TICKS   = 50;
   localparam int DEF_REPEAT_TICKS = 25;

   // Width of a counter holding 0..n-1; a 1-bit minimum keeps n == 1 legal.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // No priority between buttons: pressing both means "hold still".
   function automatic cmd_t decode_cmd(input logic up_btn, input logic dn_btn);
      if (up_btn && !dn_btn)      return CMD_UP;
      else if (dn_btn && !up_btn) return CMD_DN;
      else                        return CMD_NONE;
   endfunction

   // Returns {step_dn, step_up}; the two bits can never be set together.
   function automatic logic [1:0] step_pulse(input cmd_t d, input logic up_ok,
                                             input logic dn_ok);
      case (d)
         CMD_UP:  return {1'b0, up_ok};
         CMD_DN:  return {dn_ok, 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// -----------------------------------------------------------------------------
// counter_tick_gen
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
//   CLOCK : system clock, posedge
//   RESET : synchronous, active-high; prescaler -> 0
//   tick  : high for exactly one cycle while the prescaler sits at TICK_DIV-1
// TICK_DIV must be >= 2.
// -----------------------------------------------------------------------------
module counter_tick_gen
   import counter_ctrl_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic CLOCK,
   input  logic RESET,
   output logic tick
);

   localparam int PW = cnt_w(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;

   assign tick = (presc == LAST);

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge CLOCK) begin
      if (RESET)     presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + 1'b1;
   end

endmodule

// File: rtl/counter_step_ctrl.sv
// -----------------------------------------------------------------------------
// counter_step_ctrl
// Push-button controller for the LED up/down counter. Each press gives one
// immediate step; holding the button auto-repeats after a hold delay.
//   CLOCK   : single system clock, posedge
//   RESET   : synchronous, active-high; clears all state
//   BTN0    : count-up button (asynchronous, active-high)
//   BTN1    : count-down button (asynchronous, active-high)
//   STEP_UP : one-cycle pulse, count incremented on the following edge
//   STEP_DN : one-cycle pulse, count decremented on the following edge
//   LEDS    : current count value
//   BUSY    : high while the FSM is not IDLE
// Build option: define COUNTER_STEP_SATURATE_EN to clamp the count at
// 0 / 2^WIDTH-1 instead of wrapping; a blocked step emits no pulse.
// -----------------------------------------------------------------------------
module counter_step_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             BTN0,
   input  logic             BTN1,
   output logic             STEP_UP,
   output logic             STEP_DN,
   output logic [WIDTH-1:0] LEDS,
   output logic             BUSY
);

   localparam int HW = cnt_w(HOLD_TICKS);
   localparam int RW = cnt_w(REPEAT_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

   // ---------------------------------------------------------------- sync
   logic [1:0] sync0, sync1;
   logic       btn0_s, btn1_s;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= {sync0[0], BTN0};
         sync1 <= {sync1[0], BTN1};
      end
   end

   assign btn0_s = sync0[1];
   assign btn1_s = sync1[1];

   // ---------------------------------------------------------------- tick
   logic tick;

   counter_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .tick  (tick)
   );

   // ---------------------------------------------------------------- count
   logic [WIDTH-1:0] count_q, count_eff;
   logic             up_ok, dn_ok;
   cmd_t             cmd;

   assign cmd = decode_cmd(btn0_s, btn1_s);

   // count_eff already includes a pulse issued on the previous edge, so a
   // step decided right after another one sees the up-to-date value.
   // NOTE: always_comb assigns a default first so no path leaves the output
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      count_eff = count_q;
      if (STEP_UP)      count_eff = count_q + WIDTH'(1);
      else if (STEP_DN) count_eff = count_q - WIDTH'(1);
   end

`ifdef COUNTER_STEP_SATURATE_EN
   assign up_ok = (count_eff != '1);
   assign dn_ok = (count_eff != '0);
`else
   assign up_ok = 1'b1;
   assign dn_ok = 1'b1;
`endif

   always_ff @(posedge CLOCK) begin
      if (RESET) count_q <= '0;
      else       count_q <= count_eff;
   end

   assign LEDS = count_q;

   // ---------------------------------------------------------------- FSM
   state_t         state;
   cmd_t           dir;
   logic [HW-1:0]  hold_cnt;
   logic [RW-1:0]  rep_cnt;

   // A change of cmd wins over a coincident tick: the exit branch is tested
   // first, so no step is issued in the cycle the button set changes.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         dir      <= CMD_NONE;
         hold_cnt <= '0;
         rep_cnt  <= '0;
         STEP_UP  <= 1'b0;
         STEP_DN  <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         STEP_UP <= 1'b0;
         STEP_DN <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd != CMD_NONE) begin
                  dir                <= cmd;
                  hold_cnt           <= '0;
                  {STEP_DN, STEP_UP} <= step_pulse(cmd, up_ok, dn_ok);
                  state              <= ST_PRESS;
                  BUSY               <= 1'b1;
               end
            end
            ST_PRESS: begin
               if (cmd != dir) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end else if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     {STEP_DN, STEP_UP} <= step_pulse(dir, up_ok, dn_ok);
                     rep_cnt            <= '0;
                     state              <= ST_REPEAT;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            ST_REPEAT: begin
               if (cmd != dir) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end else if (tick) begin
                  if (rep_cnt == REP_LAST) begin
                     {STEP_DN, STEP_UP} <= step_pulse(dir, up_ok, dn_ok);
                     rep_cnt            <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_step_ctrl
// Directed scenarios plus randomized button activity against a behavioural
// model of the step controller (TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2).
// Define COUNTER_STEP_SATURATE_EN to exercise the saturating build.
// -----------------------------------------------------------------------------
module tb_counter_step_ctrl;

   localparam int WIDTH  = 4;
   localparam int TDIV   = 4;
   localparam int HOLD   = 3;
   localparam int REPEAT = 2;
   localparam int MAXV   = (1 << WIDTH) - 1;
`ifdef COUNTER_STEP_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             CLOCK = 1'b0;
   logic             RESET;
   logic             BTN0, BTN1;
   logic             STEP_UP, STEP_DN, BUSY;
   logic [WIDTH-1:0] LEDS;

   counter_step_ctrl #(
      .WIDTH(WIDTH), .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REPEAT)
   ) dut (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .BTN0    (BTN0),
      .BTN1    (BTN1),
      .STEP_UP (STEP_UP),
      .STEP_DN (STEP_DN),
      .LEDS    (LEDS),
      .BUSY    (BUSY)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_fail   = 0;
   int n_up     = 0;
   int n_dn     = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Buttons are seen two clocks late; a press is tracked as "ticks held so
   // far", with steps at the press, at HOLD ticks, then every REPEAT ticks.
   int m_b0_dly[2], m_b1_dly[2];
   int m_phase;          // clocks since reset, modulo TDIV
   bit m_active;
   int m_dir;            // 1 = up, 2 = down
   int m_ticks;
   int m_val;            // count including the pulse just issued
   int m_leds;           // what LEDS shows (m_val one clock late)
   bit m_up, m_dn;

   task automatic model_step(input int d);
      if (d == 1) begin
         if (!(SAT && m_val == MAXV)) begin
            m_up  = 1'b1;
            m_val = (m_val + 1) % (MAXV + 1);
         end
      end else begin
         if (!(SAT && m_val == 0)) begin
            m_dn  = 1'b1;
            m_val = (m_val + MAXV) % (MAXV + 1);
         end
      end
   endtask

   task automatic model_edge();
      int  c;
      bit  tk;
      m_up = 1'b0;
      m_dn = 1'b0;
      if (RESET) begin
         m_b0_dly = '{0, 0};
         m_b1_dly = '{0, 0};
         m_phase  = 0;
         m_active = 1'b0;
         m_dir    = 0;
         m_ticks  = 0;
         m_val    = 0;
         m_leds   = 0;
      end else begin
         m_leds = m_val;
         if (m_b0_dly[1] != 0 && m_b1_dly[1] == 0)      c = 1;
         else if (m_b1_dly[1] != 0 && m_b0_dly[1] == 0) c = 2;
         else                                           c = 0;
         tk = (m_phase == TDIV - 1);
         if (!m_active) begin
            if (c != 0) begin
               m_active = 1'b1;
               m_dir    = c;
               m_ticks  = 0;
               model_step(c);
            end
         end else if (c != m_dir) begin
            m_active = 1'b0;
         end else if (tk) begin
            m_ticks++;
            if (m_ticks == HOLD ||
                (m_ticks > HOLD && (m_ticks - HOLD) % REPEAT == 0))
               model_step(m_dir);
         end
         m_b0_dly[1] = m_b0_dly[0];
         m_b0_dly[0] = int'(BTN0);
         m_b1_dly[1] = m_b1_dly[0];
         m_b1_dly[0] = int'(BTN1);
         m_phase = (m_phase + 1) % TDIV;
      end
   endtask

   // One clock: update the model from the pre-edge inputs, then compare.
   task automatic cycle();
      @(posedge CLOCK);
      model_edge();
      #1;
      check("step_up", 32'(STEP_UP), 32'(m_up));
      check("step_dn", 32'(STEP_DN), 32'(m_dn));
      check("leds",    32'(LEDS),    32'(m_leds));
      check("busy",    32'(BUSY),    32'(m_active));
      n_up += int'(STEP_UP);
      n_dn += int'(STEP_DN);
   endtask

   task automatic run(input int n, input logic b0, input logic b1);
      BTN0 = b0;
      BTN1 = b1;
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
   endtask

   task automatic tap(input logic up);
      run(3, up, !up);
      run(6, 1'b0, 1'b0);
   endtask

   int k;
   bit busy_seen;
   int lv;

   initial begin
      RESET = 1'b1;
      BTN0  = 1'b0;
      BTN1  = 1'b0;
      cycle();
      cycle();
      RESET = 1'b0;
      check("rst_leds", 32'(LEDS), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_step", 32'({STEP_UP, STEP_DN}), 0);

      // 1: short press gives one step; BUSY drops 3 clocks after release
      do_reset();
      n_up = 0;
      run(6, 1'b1, 1'b0);
      BTN0 = 1'b0;
      k = 0;
      do begin
         cycle();
         k++;
      end while (BUSY && k < 20);
      check("t1_busy_fall", k, 3);
      run(4, 1'b0, 1'b0);
      check("t1_n_up", n_up, 1);
      check("t1_leds", 32'(LEDS), 1);

      // 2: 40-clock hold: press step plus repeats at +3, +5, +7, +9 ticks
      do_reset();
      n_up = 0;
      n_dn = 0;
      run(40, 1'b1, 1'b0);
      run(8, 1'b0, 1'b0);
      check("t2_n_up", n_up, 5);
      check("t2_n_dn", n_dn, 0);
      check("t2_leds", 32'(LEDS), 5);

      // 3 / 6: reach full scale, then wrap or saturate
      repeat (10) tap(1'b1);
      check("top_leds", 32'(LEDS), MAXV);
      if (!SAT) begin
         tap(1'b1);
         check("t3_wrap_up", 32'(LEDS), 0);
         tap(1'b0);
         check("t3_wrap_dn", 32'(LEDS), MAXV);
         lv = MAXV;
      end else begin
         n_up = 0;
         run(40, 1'b1, 1'b0);
         run(8, 1'b0, 1'b0);
         check("t6_n_up", n_up, 0);
         check("t6_leds", 32'(LEDS), MAXV);
         n_dn = 0;
         tap(1'b0);
         check("t6_n_dn", n_dn, 1);
         check("t6_leds_dn", 32'(LEDS), MAXV - 1);
         lv = MAXV - 1;
      end

      // 4: both buttons together never step; adding the second exits PRESS
      n_up = 0;
      n_dn = 0;
      busy_seen = 1'b0;
      BTN0 = 1'b1;
      BTN1 = 1'b1;
      repeat (30) begin
         cycle();
         busy_seen |= BUSY;
      end
      check("t4_pulses", n_up + n_dn, 0);
      check("t4_leds", 32'(LEDS), lv);
      check("t4_busy", 32'(busy_seen), 0);
      run(4, 1'b0, 1'b0);
      n_up = 0;
      run(5, 1'b1, 1'b0);
      run(20, 1'b1, 1'b1);
      check("t4_add_n_up", n_up, 1);
      check("t4_add_busy", 32'(BUSY), 0);
      check("t4_add_leds", 32'(LEDS), (lv + 1) % (MAXV + 1));
      run(4, 1'b0, 1'b0);

      // 5: reset during REPEAT, button still held -> fresh press 3 clocks on
      do_reset();
      run(55, 1'b1, 1'b0);
      check("t5_pre_leds", 32'(LEDS), 7);
      check("t5_pre_busy", 32'(BUSY), 1);
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      check("t5_rst_leds", 32'(LEDS), 0);
      check("t5_rst_busy", 32'(BUSY), 0);
      check("t5_rst_step", 32'(STEP_UP), 0);
      k = 0;
      do begin
         cycle();
         k++;
      end while (!STEP_UP && k < 20);
      check("t5_restep_lat", k, 3);
      run(6, 1'b0, 1'b0);

      // randomized activity, long holds included, occasional reset
      do_reset();
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 24) == 0) begin
            BTN0 = 1'($urandom_range(0, 1));
            BTN1 = 1'($urandom_range(0, 1));
            do_reset();
         end else begin
            run($urandom_range(1, 40), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_step_ctrl.md
Name: counter_step_ctrl

Overview:
Controller that sequences the 4-bit LED up/down counter from the two push-buttons.
- Synchronises BTN0/BTN1 and arbitrates between them.
- On a press, issues one immediate step, then auto-repeats after a hold delay.
- Owns the count register and drives LEDS.
- Sits between the board buttons and the LEDs, replacing free-running divided-clock counting with single-clock, tick-enabled stepping.

Parameters:
WIDTH, 4, count/LED width
TICK_DIV, 1250000, CLOCK cycles per tick (10 ms at 125 MHz); must be >= 2
HOLD_TICKS, 50, ticks a button must stay held before auto-repeat starts; >= 1
REPEAT_TICKS, 25, ticks between auto-repeat steps; >= 1

Ports:
CLOCK  input  1  single system clock, all logic on posedge
RESET  input  1  synchronous, active-high; clears all state
BTN0  input  1  count-up button, asynchronous, active-high
BTN1  input  1  count-down button, asynchronous, active-high
STEP_UP  output  1  one-cycle pulse, count incremented
STEP_DN  output  1  one-cycle pulse, count decremented
LEDS  output  WIDTH  current count value
BUSY  output  1  high while FSM not IDLE

Behaviour:
- Reset (sync, active-high): all of the following clear. No pulse in the reset cycle.
  - synchronisers, prescaler, hold/repeat counters -> 0
  - FSM -> IDLE
  - LEDS = 0, STEP_UP = STEP_DN = BUSY = 0
- Reset mid-PRESS/REPEAT aborts immediately. A button still held after reset release is treated as a new press.
- Sync: 2-flop synchroniser per button, giving btn0_s/btn1_s.
- Tick: prescaler counts 0..TICK_DIV-1 and free-runs. tick = 1 for exactly one cycle when prescaler == TICK_DIV-1, then prescaler wraps to 0.
- Arbitration (no priority): cmd is derived as follows.
  - UP if btn0_s & !btn1_s
  - DN if btn1_s & !btn0_s
  - NONE otherwise; both pressed means hold.
- FSM states IDLE, PRESS, REPEAT. dir is latched on entry to PRESS.
  - IDLE:
    - cmd != NONE: emit step in dir, hold_cnt = 0, go PRESS.
    - Otherwise stay in IDLE.
  - PRESS:
    - cmd != dir (release, both, or opposite): go IDLE, no step. An opposite button starts its own press on the next cycle.
    - Else on tick:
      - if hold_cnt == HOLD_TICKS-1: emit step, rep_cnt = 0, go REPEAT
      - else hold_cnt++
  - REPEAT:
    - cmd != dir: go IDLE.
    - Else on tick:
      - if rep_cnt == REPEAT_TICKS-1: emit step, rep_cnt = 0
      - else rep_cnt++
  - cmd change takes precedence over a coincident tick; no step is emitted in that cycle.
- Step: STEP_UP/STEP_DN are registered and mutually exclusive; never both high.
  - LEDS takes the new value on the edge after the pulse cycle.
  - Arithmetic is modulo 2^WIDTH: 15+1 -> 0, 0-1 -> 15.
- Latency: BTN0 rises before edge 0 -> STEP_UP high after edge 2 -> LEDS updated after edge 3.
- First hold-repeat step occurs HOLD_TICKS ticks after the press step. Because of tick phase, that is between (HOLD_TICKS-1)*TICK_DIV+1 and HOLD_TICKS*TICK_DIV cycles.
- BUSY = (state != IDLE).

Optional Feature:
Macro COUNTER_STEP_SATURATE_EN.
- Defined: count saturates.
  - An UP step at 2^WIDTH-1 or a DN step at 0 produces no STEP pulse and leaves LEDS unchanged.
  - FSM sequencing is unchanged.
- Undefined: wrap-around as specified in Behaviour.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state enum (IDLE, PRESS, REPEAT)
  - cmd enum (NONE, UP, DN)
  - default-parameter localparams
- One sub-module, counter_tick_gen (prescaler, parameter TICK_DIV, output tick), reused by future timed blocks.
- Synchronisers, FSM and count register stay in counter_step_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.
1. Reset, then BTN0 high for 6 cycles -> exactly one STEP_UP; LEDS 0 -> 1; BUSY falls 3 cycles after BTN0 drops.
2. BTN0 held 40 cycles from LEDS=0 -> press step, repeat after 3 ticks, then every 2 ticks; STEP_UP count matches that timing; LEDS equals the pulse count; no STEP_DN.
3. Wrap (macro off): LEDS=15, BTN0 tap -> LEDS=0; then BTN1 tap -> LEDS=15.
4. Concurrent buttons:
   - BTN0 and BTN1 asserted in the same cycle for 30 cycles -> no STEP pulses, LEDS unchanged, BUSY=0.
   - BTN0 held then BTN1 added -> FSM returns to IDLE with no further steps.
5. RESET pulsed 1 cycle during REPEAT at LEDS=7 -> next cycle LEDS=0, BUSY=0, no pulse. BTN0 still held -> a new press step occurs 3 cycles after reset release.
6. Saturation (COUNTER_STEP_SATURATE_EN): LEDS=15, BTN0 held 40 cycles -> no STEP_UP, LEDS stays 15. Then BTN1 tap -> STEP_DN, LEDS=14.
